// File: rtl/uart_rx_core_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants,
// and the baud divisor formula (also used by the transmitter).
package uart_rx_core_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_MID_SAMPLE = 8;

    typedef enum logic [2:0] {
        ST_WAIT_HIGH = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
    } rx_state_t;

    // Truncating divide, never below 1 so the tick generator always advances.
    function automatic int unsigned uart_divisor(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        int unsigned d;
        d = clk_freq / (UART_OVERSAMPLE * baud_rate);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_core_baud_tick.sv
// Oversampling tick generator: down-counter that fires one cycle every
// `divisor` clocks; `restart` reloads it so the next tick is a full period away.
module uart_rx_core_baud_tick #(
    parameter int unsigned divisor = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W  = (divisor > 1) ? $clog2(divisor) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(divisor - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RELOAD;
        end else if (restart || (cnt == '0)) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote per bit,
// and a held-until-acknowledged output byte with framing/overrun flags.
//
// state      | meaning
// WAIT_HIGH  | after reset or break: wait for the line to read 1 on a tick
// IDLE       | line idle, waiting for a falling edge
// START      | validating start bit at mid-bit, glitches return to IDLE
// DATA       | shifting in 8 data bits LSB first
// STOP       | sampling stop bit; 0 means framing error / break
module uart_rx_core
    import uart_rx_core_pkg::*;
#(
    parameter int unsigned clk_freq       = 100000000,
    parameter int unsigned uart_baud_rate = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       rx_error,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int unsigned DIVISOR = uart_divisor(clk_freq, uart_baud_rate);

    // Tick counter value v corresponds to tick number v+1 within a bit, so the
    // votes land on ticks 7, 8, 9 and the stop sample on tick 8.
    localparam logic [3:0] VOTE_A      = 4'(UART_MID_SAMPLE - 2);
    localparam logic [3:0] VOTE_B      = 4'(UART_MID_SAMPLE - 1);
    localparam logic [3:0] VOTE_C      = 4'(UART_MID_SAMPLE);
    localparam logic [3:0] STOP_SAMPLE = 4'(UART_MID_SAMPLE - 1);

    logic       rxd_meta;
    logic       rxd_sync;
    rx_state_t  state;
    logic [3:0] tcnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       s0;
    logic       s1;
    logic       stop_bit;
    logic       done;
    logic       tick;
    logic       restart;
    logic       vote;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
        end
    end

    assign restart = (state == ST_IDLE) && !rxd_sync;
    assign vote    = maj3(s0, s1, rxd_sync);

    uart_rx_core_baud_tick #(
        .divisor(DIVISOR)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_WAIT_HIGH;
            tcnt     <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            s0       <= 1'b1;
            s1       <= 1'b1;
            stop_bit <= 1'b1;
            done     <= 1'b0;
            rx_busy  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_WAIT_HIGH: begin
                    if (tick && rxd_sync) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (!rxd_sync) begin
                        state   <= ST_START;
                        tcnt    <= '0;
                        rx_busy <= 1'b1;
                    end
                end
                ST_START, ST_DATA: begin
                    if (tick) begin
                        // Free-running 4-bit count keeps later votes centred on each bit.
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == VOTE_A) s0 <= rxd_sync;
                        if (tcnt == VOTE_B) s1 <= rxd_sync;
                        if (tcnt == VOTE_C) begin
                            if (state == ST_START) begin
                                if (vote) begin
                                    state   <= ST_IDLE;
                                    rx_busy <= 1'b0;
                                end else begin
                                    state   <= ST_DATA;
                                    bit_idx <= '0;
                                end
                            end else begin
                                shreg   <= {vote, shreg[7:1]};
                                bit_idx <= bit_idx + 3'd1;
                                if (bit_idx == 3'd7) state <= ST_STOP;
                            end
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        tcnt <= tcnt + 4'd1;
                        if (tcnt == STOP_SAMPLE) begin
                            stop_bit <= rxd_sync;
                            done     <= 1'b1;
                            rx_busy  <= 1'b0;
                            state    <= rxd_sync ? ST_IDLE : ST_WAIT_HIGH;
                        end
                    end
                end
                default: begin
                    state   <= ST_WAIT_HIGH;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    // A completing byte takes priority over a same-cycle acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_avail   <= 1'b0;
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (done) begin
            rx_data  <= shreg;
            rx_avail <= 1'b1;
            rx_error <= !stop_bit;
            if (rx_avail && !rx_ack) begin
                rx_overrun <= 1'b1;
            end else if (rx_avail && rx_ack) begin
                rx_overrun <= 1'b0;
            end
        end else if (rx_ack && rx_avail) begin
            rx_avail   <= 1'b0;
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed + randomized bench for uart_rx_core at 625 kbaud / 100 MHz
// (divisor 10, 160 clk per bit) against a behavioural output-flag model.
module tb_uart_rx_core;

    localparam int BIT = 160;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_error;
    logic       rx_overrun;
    logic       rx_busy;

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;
    int avail_rises = 0;
    int busy_rises = 0;
    logic avail_prev = 1'b0;
    logic busy_prev = 1'b0;

    logic [7:0] exp_data;
    logic       exp_avail;
    logic       exp_err;
    logic       exp_ovr;

    uart_rx_core #(
        .clk_freq      (100000000),
        .uart_baud_rate(625000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rxd  (uart_rxd),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_avail  (rx_avail),
        .rx_error  (rx_error),
        .rx_overrun(rx_overrun),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_avail && !avail_prev) begin
            rise_cyc = cyc;
            avail_rises++;
        end
        if (rx_busy && !busy_prev) busy_rises++;
        avail_prev = rx_avail;
        busy_prev  = rx_busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output-flag model: what the consumer should see after each event.
    task automatic model_frame(input logic [7:0] b, input logic err, input logic ack_same);
        if (exp_avail && !ack_same) exp_ovr = 1'b1;
        else if (ack_same)          exp_ovr = 1'b0;
        exp_data  = b;
        exp_avail = 1'b1;
        exp_err   = err;
    endtask

    task automatic model_ack();
        if (exp_avail) begin
            exp_avail = 1'b0;
            exp_err   = 1'b0;
            exp_ovr   = 1'b0;
        end
    endtask

    task automatic model_reset();
        exp_data  = '0;
        exp_avail = 1'b0;
        exp_err   = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_data"},    {24'd0, rx_data}, {24'd0, exp_data});
        chk({tag, "_avail"},   {31'd0, rx_avail}, {31'd0, exp_avail});
        chk({tag, "_error"},   {31'd0, rx_error}, {31'd0, exp_err});
        chk({tag, "_overrun"}, {31'd0, rx_overrun}, {31'd0, exp_ovr});
    endtask

    task automatic send_frame(input logic [7:0] b, input int bit_clks,
                              input logic stop_val, input int stop_clks);
        @(negedge clk);
        uart_rxd = 1'b0;
        fall_cyc = cyc;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (bit_clks) @(negedge clk);
        end
        uart_rxd = stop_val;
        repeat (stop_clks) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (bit_clks) @(negedge clk);
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        model_ack();
        chk({tag, "_ack_clears_avail"}, {31'd0, rx_avail}, {31'd0, exp_avail});
    endtask

    // Completion cycle is the first cycle in which rx_busy reads low again.
    task automatic ack_at_completion();
        bit seen_busy = 1'b0;
        bit seen_done = 1'b0;
        for (int i = 0; i < 3000 && !seen_busy; i++) begin
            @(negedge clk);
            if (rx_busy) seen_busy = 1'b1;
        end
        for (int i = 0; i < 3000 && seen_busy && !seen_done; i++) begin
            @(negedge clk);
            if (!rx_busy) seen_done = 1'b1;
        end
        chk("t4_completion_seen", {31'd0, seen_done}, 32'd1);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    initial begin
        int lat;
        int br;
        int ar;
        logic [7:0] b;
        int bits;
        logic ack_now;
        logic [7:0] skew_bytes [3];
        skew_bytes[0] = 8'h00;
        skew_bytes[1] = 8'hFF;
        skew_bytes[2] = 8'h6B;

        rst = 1'b1;
        uart_rxd = 1'b1;
        rx_ack = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check_outputs("reset");
        chk("reset_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // 1: clean byte and latency
        send_frame(8'hA5, BIT, 1'b1, BIT);
        model_frame(8'hA5, 1'b0, 1'b0);
        lat = rise_cyc - fall_cyc;
        chk($sformatf("t1_latency_%0d_in_1510_1530", lat),
            {31'd0, (lat >= 1510 && lat <= 1530)}, 32'd1);
        check_outputs("t1");
        do_ack("t1");

        // 2: glitch rejection
        br = busy_rises;
        ar = avail_rises;
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (40) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (300) @(negedge clk);
        chk("t2_busy_pulsed", busy_rises - br, 32'd1);
        chk("t2_no_avail", avail_rises - ar, 32'd0);
        chk("t2_busy_low", {31'd0, rx_busy}, 32'd0);
        send_frame(8'h3C, BIT, 1'b1, BIT);
        model_frame(8'h3C, 1'b0, 1'b0);
        check_outputs("t2_3c");
        do_ack("t2");

        // 3: framing error with long low stop
        br = busy_rises;
        send_frame(8'h55, BIT, 1'b0, 2 * BIT);
        model_frame(8'h55, 1'b1, 1'b0);
        chk("t3_no_restart_while_low", busy_rises - br, 32'd1);
        check_outputs("t3");
        do_ack("t3");
        send_frame(8'h0F, BIT, 1'b1, BIT);
        model_frame(8'h0F, 1'b0, 1'b0);
        check_outputs("t3_0f");
        do_ack("t3b");

        // 4: overrun, then ack coinciding with completion
        send_frame(8'h11, BIT, 1'b1, BIT);
        model_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, BIT, 1'b1, BIT);
        model_frame(8'h22, 1'b0, 1'b0);
        check_outputs("t4_overrun");
        do_ack("t4");
        chk("t4_ack_clears_overrun", {31'd0, rx_overrun}, 32'd0);
        send_frame(8'h11, BIT, 1'b1, BIT);
        model_frame(8'h11, 1'b0, 1'b0);
        fork
            send_frame(8'h22, BIT, 1'b1, BIT);
            ack_at_completion();
        join
        model_frame(8'h22, 1'b0, 1'b1);
        check_outputs("t4_simul_ack");

        // 5: reset during data bit 3 of 0xFF; held byte must be cleared
        ar = avail_rises;
        fork
            send_frame(8'hFF, BIT, 1'b1, BIT);
            begin
                repeat (4 * BIT + 80) @(negedge clk);
                rst = 1'b1;
                repeat (5) @(negedge clk);
                model_reset();
                check_outputs("t5_in_reset");
                chk("t5_busy", {31'd0, rx_busy}, 32'd0);
                rst = 1'b0;
            end
        join
        chk("t5_no_partial_byte", avail_rises - ar, 32'd0);
        check_outputs("t5_after");
        send_frame(8'h81, BIT, 1'b1, BIT);
        model_frame(8'h81, 1'b0, 1'b0);
        check_outputs("t5_81");
        do_ack("t5");

        // 6: +/-3% sender skew
        for (int s = 0; s < 2; s++) begin
            bits = (s == 0) ? 155 : 165;
            for (int k = 0; k < 3; k++) begin
                send_frame(skew_bytes[k], bits, 1'b1, bits);
                model_frame(skew_bytes[k], 1'b0, 1'b0);
                check_outputs($sformatf("t6_p%0d_b%0h", bits, skew_bytes[k]));
                do_ack("t6");
            end
        end

        // Randomized bytes, rates within tolerance, random consumer behaviour
        for (int r = 0; r < 8; r++) begin
            b = 8'($urandom);
            bits = 155 + int'($urandom_range(10));
            ack_now = 1'($urandom_range(1));
            send_frame(b, bits, 1'b1, bits);
            model_frame(b, 1'b0, 1'b0);
            check_outputs($sformatf("rand%0d_b%0h_p%0d", r, b, bits));
            if (ack_now) do_ack("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
